// File: rtl/serdes_nch_ddr_ser.sv
// N-lane W:2 parallel-to-DDR serialiser with valid/ready holding register, idle insertion and sticky underflow.
// Optional clock-lane outputs are enabled by defining SERDES_CLK_LANE_EN.
`timescale 1ns/1ps
module serdes_nch_ddr_ser #(
    parameter int                CH        = 4,
    parameter int                WORD_W    = 10,
    parameter int                MSB_FIRST = 0,
    parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*WORD_W-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 phase_restart,
    input  logic                 clr_underflow,
    output logic [CH-1:0]        out_h,
    output logic [CH-1:0]        out_l,
    output logic                 frame_start,
    output logic                 underflow
`ifdef SERDES_CLK_LANE_EN
    ,
    output logic                 clk_lane_h,
    output logic                 clk_lane_l
`endif
);

    localparam int R    = WORD_W / 2;
    localparam int PH_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

    logic [PH_W-1:0]              ph_q, ph_d;
    logic [CH-1:0][WORD_W-1:0]    sh_q, sh_d;
    logic [CH-1:0][WORD_W-1:0]    hold_q;
    logic                         hold_full_q, hold_full_d;
    logic                         armed_q, armed_d;
    logic                         uf_q, uf_d;
    logic                         load_now;
    logic                         xfer;
    logic                         uf_set;

    always_comb begin
        load_now    = (ph_q == PH_LAST) | phase_restart;
        din_ready   = ~hold_full_q | load_now;
        xfer        = din_valid & din_ready;
        ph_d        = load_now ? '0 : ph_q + 1'b1;
        hold_full_d = hold_full_q;
        armed_d     = armed_q | xfer;
        uf_set      = load_now & ~hold_full_q & armed_q;
        sh_d        = sh_q;

        if (load_now) begin
            // No bypass: a word arriving on a load cycle always waits in hold.
            sh_d        = hold_full_q ? hold_q : {CH{IDLE_WORD}};
            hold_full_d = 1'b0;
        end else begin
            for (int n = 0; n < CH; n++) begin
                if (MSB_FIRST != 0)
                    sh_d[n] = {sh_q[n][WORD_W-3:0], 2'b00};
                else
                    sh_d[n] = {2'b00, sh_q[n][WORD_W-1:2]};
            end
        end

        if (xfer)
            hold_full_d = 1'b1;

        uf_d = uf_set | (uf_q & ~clr_underflow);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q        <= '0;
            sh_q        <= {CH{IDLE_WORD}};
            hold_full_q <= 1'b0;
            armed_q     <= 1'b0;
            uf_q        <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            sh_q        <= sh_d;
            hold_full_q <= hold_full_d;
            armed_q     <= armed_d;
            uf_q        <= uf_d;
        end
    end

    // Holding data is payload only; its validity lives in hold_full_q.
    always_ff @(posedge clk) begin
        if (xfer)
            hold_q <= din;
    end

    for (genvar n = 0; n < CH; n++) begin : g_lane
        if (MSB_FIRST != 0) begin : g_msb
            assign out_h[n] = sh_q[n][WORD_W-1];
            assign out_l[n] = sh_q[n][WORD_W-2];
        end else begin : g_lsb
            assign out_h[n] = sh_q[n][0];
            assign out_l[n] = sh_q[n][1];
        end
    end

    assign frame_start = (ph_q == '0);
    assign underflow   = uf_q;

`ifdef SERDES_CLK_LANE_EN
    logic clk_h_q, clk_h_d;
    logic clk_l_q, clk_l_d;

    always_comb begin
        clk_h_d = ((2 * int'(ph_d)) < R);
        clk_l_d = ((2 * int'(ph_d) + 1) < R);
    end

    // Reset values are the ph = 0 pattern (both high since R >= 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_h_q <= 1'b1;
            clk_l_q <= 1'b1;
        end else begin
            clk_h_q <= clk_h_d;
            clk_l_q <= clk_l_d;
        end
    end

    assign clk_lane_h = clk_h_q;
    assign clk_lane_l = clk_l_q;
`endif

endmodule
